// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus bundle between the CPU side (master) and the UART responder (slave).
interface uart_tx_mmio_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        hit_o;

  modport master (output ce, we, addr, sel, data_i, input data_o, hit_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o, hit_o);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO on the OpenMIPS data bus.
// Optional interrupt output enabled by defining UART_TX_IRQ_EN.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           txd_o,
  output logic           irq_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  logic        ovf_q;
  logic [15:0] div_q;
  logic        en_q;
  logic        irqen_rd;
  logic        hit, wr, push, push_ok, pop, clr_ovf, full, empty, bit_end, busy;
  logic [1:0]  off;
  logic [4:0]  cnt5;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit     = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off     = bus.addr[3:2];
  assign wr      = hit && bus.we && (bus.sel == 4'b1111);
  assign push    = wr && (off == 2'd0);
  assign clr_ovf = wr && (off == 2'd1) && bus.data_i[3];
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == IDLE) && en_q && !empty;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok = push && (!full || pop);
  assign bit_end = (cnt_q >= div_q);
  assign cnt5    = 5'(count_q);
  assign unused_bits = ^{bus.addr[1:0], bus.data_i[31:16]};

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= bus.data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      div_q   <= DEFAULT_DIV;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      if (push && !push_ok) ovf_q <= 1'b1;
      else if (clr_ovf)     ovf_q <= 1'b0;
      if (wr && off == 2'd2) div_q <= bus.data_i[15:0];
      if (wr && off == 2'd3) en_q  <= bus.data_i[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q != IDLE && !bit_end) cnt_d = cnt_q + 16'd1;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          state_d = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_o = 1'b1;
    busy  = (state_q != IDLE);
    case (state_q)
      START:   txd_o = 1'b0;
      DATA:    txd_o = shift_q[0];
      default: txd_o = 1'b1;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  logic irqen_q, irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr && off == 2'd3) irqen_q <= bus.data_i[1];
      if (push || !irqen_q)
        irq_q <= 1'b0;
      else if (state_q == STOP && bit_end && empty)
        irq_q <= 1'b1;
    end
  end

  assign irq_o    = irq_q;
  assign irqen_rd = irqen_q;
`else
  assign irq_o    = 1'b0;
  assign irqen_rd = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit && !bus.we) begin
      case (off)
        2'd1:    rdata = {23'd0, cnt5, ovf_q, empty, full, busy};
        2'd2:    rdata = {16'd0, div_q};
        2'd3:    rdata = {30'd0, irqen_rd, en_q};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.data_o = rdata;
  assign bus.hit_o  = hit;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register access, framing, FIFO overflow, reset abort, irq.
module tb_uart_tx_mmio;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst;
  logic txd, irq;
  logic irq_seen = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .txd_o(txd),
    .irq_o(irq)
  );

  always @(negedge clk) if (irq === 1'b1) irq_seen = 1'b1;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.sel = s; bus.data_i = d;
    @(posedge clk);
    #1;
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a; bus.sel = 4'hF;
    #1;
    d = bus.data_o;
    h = bus.hit_o;
    bus.ce = 1'b0;
  endtask

  // Waits for a start bit, samples mid-bit, and compares the byte with the scoreboard head.
  task automatic recv_check(input int div);
    int waited = 0;
    int cur = 0;
    logic [9:0] line;
    logic [7:0] expv;
    while (txd !== 1'b0 && waited < 20000) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (txd !== 1'b0) begin
      $display("FAIL rx_start: txd=%b required 0 within budget", txd);
      return;
    end
    passes++;
    for (int k = 0; k < 10; k++) begin
      while (cur < k * (div + 1) + div / 2) begin
        @(posedge clk); #1; cur++;
      end
      line[k] = txd;
    end
    checks++;
    if (line[0] !== 1'b0 || line[9] !== 1'b1) begin
      $display("FAIL rx_framing: start=%b stop=%b required 0/1", line[0], line[9]);
    end else passes++;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL rx_unexpected: got byte %h with empty scoreboard", line[8:1]);
    end else begin
      expv = exp_q.pop_front();
      if (line[8:1] !== expv)
        $display("FAIL rx_byte: got %h required %h", line[8:1], expv);
      else passes++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic h;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b required 1", txd); else passes++;
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b required 0", irq); else passes++;
    peek(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h0000_0004) $display("FAIL reset_status: got %h required 00000004", d); else passes++;
    peek(BASE + 32'h8, d, h);
    checks++; if (d !== 32'd433) $display("FAIL reset_baud: got %0d required 433", d); else passes++;
    peek(BASE + 32'hC, d, h);
    checks++; if (d !== 32'd0) $display("FAIL reset_ctrl: got %h required 0", d); else passes++;
    peek(BASE, d, h);
    checks++; if (d !== 32'd0) $display("FAIL txdata_read: got %h required 0", d); else passes++;
  endtask

  task automatic test_regs();
    logic [31:0] d; logic h;
    bus_write(BASE + 32'hA, 32'hFFFF_0003, 4'hF);
    peek(BASE + 32'h9, d, h);
    checks++; if (d !== 32'd3) $display("FAIL baud_rw: got %h required 3", d); else passes++;
    checks++; if (h !== 1'b1) $display("FAIL hit_in: got %b required 1", h); else passes++;
    bus_write(BASE + 32'hC, 32'h2, 4'hF);
    peek(BASE + 32'hC, d, h);
`ifdef UART_TX_IRQ_EN
    checks++; if (d !== 32'd2) $display("FAIL ctrl_rw: got %h required 2", d); else passes++;
`else
    checks++; if (d !== 32'd0) $display("FAIL ctrl_rw: got %h required 0", d); else passes++;
`endif
    bus_write(BASE + 32'hC, 32'h0, 4'hF);
    bus_write(BASE, 32'h77, 4'b0001);
    peek(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h4) $display("FAIL partial_write: status %h required 00000004", d); else passes++;
    peek(32'h2000_0004, d, h);
    checks++; if (h !== 1'b0) $display("FAIL hit_out: got %b required 0", h); else passes++;
    checks++; if (d !== 32'd0) $display("FAIL data_out_miss: got %h required 0", d); else passes++;
  endtask

  task automatic test_frame();
    logic [31:0] d; logic h;
    logic [9:0] line;
    line = {1'b1, 8'hA5, 1'b0};
    bus_write(BASE + 32'hC, 32'h1, 4'hF);
    bus_write(BASE, 32'hA5, 4'hF);
    checks++; if (txd !== 1'b1) $display("FAIL frame_latency: txd %b required 1 after write edge", txd); else passes++;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (txd !== line[i / 4]) $display("FAIL frame_bit%0d: got %b required %b", i, txd, line[i / 4]);
      else passes++;
      if (i == 20) begin
        peek(BASE + 32'h4, d, h);
        checks++; if (d[0] !== 1'b1) $display("FAIL busy_mid: got %b required 1", d[0]); else passes++;
      end
      @(posedge clk); #1;
    end
    peek(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h4) $display("FAIL busy_after: status %h required 00000004", d); else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic h;
    logic [7:0] b;
    int lows = 0;
    bus_write(BASE + 32'hC, 32'h0, 4'hF);
    for (int k = 0; k < 9; k++) begin
      b = 8'(k * 29 + 49);
      bus_write(BASE, {24'd0, b}, 4'hF);
      if (k < 8) exp_q.push_back(b);
    end
    peek(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h8A) $display("FAIL overflow_status: got %h required 0000008a", d); else passes++;
    bus_write(BASE + 32'h4, 32'h8, 4'hF);
    peek(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h82) $display("FAIL overflow_clear: got %h required 00000082", d); else passes++;
    bus_write(BASE + 32'hC, 32'h1, 4'hF);
    for (int k = 0; k < 8; k++) recv_check(3);
    repeat (60) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) $display("FAIL ninth_byte: %0d low cycles required 0", lows); else passes++;
    checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left: %0d bytes required 0", exp_q.size()); else passes++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic h;
    int lows = 0;
    bus_write(BASE, 32'h3C, 4'hF);
    repeat (12) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (txd !== 1'b1) $display("FAIL reset_abort_txd: got %b required 1", txd); else passes++;
    rst = 1'b0;
    peek(BASE + 32'h4, d, h);
    checks++; if (d !== 32'h4) $display("FAIL reset_abort_status: got %h required 00000004", d); else passes++;
    repeat (60) begin
      @(posedge clk); #1;
      if (txd !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) $display("FAIL reset_residual: %0d low cycles required 0", lows); else passes++;
  endtask

  task automatic test_irq();
`ifdef UART_TX_IRQ_EN
    bus_write(BASE + 32'h8, 32'h3, 4'hF);
    bus_write(BASE + 32'hC, 32'h3, 4'hF);
    bus_write(BASE, 32'h5A, 4'hF);
    exp_q.push_back(8'h5A);
    checks++; if (irq !== 1'b0) $display("FAIL irq_early: got %b required 0", irq); else passes++;
    recv_check(3);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) $display("FAIL irq_before_stop_end: got %b required 0", irq); else passes++;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) $display("FAIL irq_rise: got %b required 1", irq); else passes++;
    bus_write(BASE, 32'hC3, 4'hF);
    exp_q.push_back(8'hC3);
    checks++; if (irq !== 1'b0) $display("FAIL irq_push_clear: got %b required 0", irq); else passes++;
    recv_check(3);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b1) $display("FAIL irq_second: got %b required 1", irq); else passes++;
    bus_write(BASE + 32'hC, 32'h1, 4'hF);
    checks++; if (irq !== 1'b0) $display("FAIL irq_en_clear: got %b required 0", irq); else passes++;
`else
    bus_write(BASE + 32'h8, 32'h3, 4'hF);
    bus_write(BASE + 32'hC, 32'h3, 4'hF);
    bus_write(BASE, 32'h5A, 4'hF);
    exp_q.push_back(8'h5A);
    recv_check(3);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (irq_seen !== 1'b0) $display("FAIL irq_tied: seen %b required 0", irq_seen); else passes++;
`endif
  endtask

  initial begin
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
    rst = 1'b1;
    test_reset();
    test_regs();
    test_frame();
    test_overflow();
    test_mid_reset();
    test_irq();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
